// File: rtl/dco_freq_lock_ctrl_if.sv
// Handshake/data bundle between the DCO lock controller and its environment.
// The slave side is the controller; the master side drives start, fcw and the sampled phase.
interface dco_freq_lock_ctrl_if #(
   parameter int CTRL_W  = 16,
   parameter int PHASE_W = 32
);
   logic                      start;
   logic [PHASE_W-1:0]        fcw;
   logic [PHASE_W-1:0]        dco_phase;
   logic signed [CTRL_W-1:0]  dctrl;
   logic                      busy;
   logic                      search_done;
   logic                      lock;
   logic signed [PHASE_W:0]   ferr;

   modport master (
      output start, fcw, dco_phase,
      input  dctrl, busy, search_done, lock, ferr
   );

   modport slave (
      input  start, fcw, dco_phase,
      output dctrl, busy, search_done, lock, ferr
   );
endinterface

// File: rtl/dco_freq_lock_ctrl.sv
// DCO frequency acquisition: binary search over the control code, then an integral
// tracking loop that reports lock once the per-cycle phase increment matches the FCW.
module dco_freq_lock_ctrl #(
   parameter int CTRL_W     = 16,
   parameter int PHASE_W    = 32,
   parameter int SETTLE_CYC = 4,
   parameter int GAIN_SHIFT = 2,
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_CNT   = 8
) (
   input  logic                refclk,
   input  logic                resetn,
   dco_freq_lock_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_TRACK  = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   localparam int BIT_W  = $clog2(CTRL_W);
   localparam int LCNT_W = $clog2(LOCK_CNT + 1);

   localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYC);
   localparam logic [CTRL_W-1:0]  CODE_MID    = {1'b1, {(CTRL_W-1){1'b0}}};
   localparam logic [BIT_W-1:0]   BIT_TOP     = BIT_W'(CTRL_W - 1);
   localparam logic [LCNT_W-1:0]  LCNT_LAST   = LCNT_W'(LOCK_CNT - 1);
   localparam logic [LCNT_W-1:0]  LCNT_FULL   = LCNT_W'(LOCK_CNT);
   localparam logic [PHASE_W:0]   TOL_MAG     = (PHASE_W+1)'(LOCK_TOL);

   // code - step, clamped to the unsigned code range instead of wrapping
   function automatic logic [CTRL_W-1:0] sat_code(input logic [CTRL_W-1:0] code,
                                                  input logic signed [PHASE_W:0] step);
      logic signed [PHASE_W+1:0] sum;
      logic [CTRL_W-1:0]         res;
      sum = $signed({{(PHASE_W+2-CTRL_W){1'b0}}, code}) - $signed({step[PHASE_W], step});
      if (sum[PHASE_W+1]) begin
         res = {CTRL_W{1'b0}};
      end else if (|sum[PHASE_W:CTRL_W]) begin
         res = {CTRL_W{1'b1}};
      end else begin
         res = sum[CTRL_W-1:0];
      end
      return res;
   endfunction

   logic [1:0]              state_q, state_d;
   logic [CTRL_W-1:0]       code_q, code_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [7:0]              icnt_q, icnt_d;
   logic [LCNT_W-1:0]       lcnt_q, lcnt_d;
   logic [PHASE_W-1:0]      fcw_q, fcw_d;
   logic [PHASE_W-1:0]      phase_q;
   logic signed [PHASE_W:0] ferr_q, ferr_d;
   logic                    done_q, done_d;
   logic                    busy_q, lock_q;

   logic [PHASE_W-1:0]      delta_s, diff_s;
   logic signed [PHASE_W:0] ferr_s, step_s;
   logic [PHASE_W:0]        mag_s;
   logic                    meas_s, fast_s, in_tol_s;
   logic [BIT_W-1:0]        bit_dec_s;

   // Modular subtraction keeps the increment correct across accumulator wrap
   assign delta_s   = bus.dco_phase - phase_q;
   assign diff_s    = delta_s - fcw_q;
   assign ferr_s    = $signed({diff_s[PHASE_W-1], diff_s});
   assign step_s    = ferr_s >>> GAIN_SHIFT;
   assign mag_s     = ferr_s[PHASE_W] ? $unsigned(-ferr_s) : $unsigned(ferr_s);
   assign meas_s    = (icnt_q == SETTLE_LAST);
   assign fast_s    = !ferr_s[PHASE_W] && (ferr_s != '0);
   assign in_tol_s  = (mag_s <= TOL_MAG);
   assign bit_dec_s = bit_q - BIT_W'(1);

   // Next-state logic: start overrides everything, otherwise act on measurement edges
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      bit_d   = bit_q;
      icnt_d  = icnt_q;
      lcnt_d  = lcnt_q;
      fcw_d   = fcw_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      if (bus.start) begin
         fcw_d   = bus.fcw;
         code_d  = CODE_MID;
         bit_d   = BIT_TOP;
         icnt_d  = 8'd0;
         state_d = ST_SEARCH;
      end else if (state_q == ST_IDLE) begin
         icnt_d = 8'd0;
      end else if (!meas_s) begin
         icnt_d = icnt_q + 8'd1;
      end else begin
         icnt_d = 8'd0;
         ferr_d = ferr_s;
         case (state_q)
            ST_SEARCH: begin
               code_d[bit_q] = code_q[bit_q] & ~fast_s;
               if (bit_q != '0) begin
                  code_d[bit_dec_s] = 1'b1;
                  bit_d             = bit_dec_s;
               end else begin
                  done_d  = 1'b1;
                  lcnt_d  = '0;
                  state_d = ST_TRACK;
               end
            end
            ST_TRACK, ST_LOCKED: begin
               code_d = sat_code(code_q, step_s);
               if (!in_tol_s) begin
                  lcnt_d  = '0;
                  state_d = ST_TRACK;
               end else if (lcnt_q >= LCNT_LAST) begin
                  lcnt_d  = LCNT_FULL;
                  state_d = ST_LOCKED;
               end else begin
                  lcnt_d  = lcnt_q + LCNT_W'(1);
                  state_d = ST_TRACK;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge refclk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         code_q  <= CODE_MID;
         bit_q   <= BIT_TOP;
         icnt_q  <= 8'd0;
         lcnt_q  <= '0;
         fcw_q   <= '0;
         phase_q <= '0;
         ferr_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         bit_q   <= bit_d;
         icnt_q  <= icnt_d;
         lcnt_q  <= lcnt_d;
         fcw_q   <= fcw_d;
         phase_q <= bus.dco_phase;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         busy_q  <= (state_d != ST_IDLE);
         lock_q  <= (state_d == ST_LOCKED);
      end
   end

   assign bus.dctrl       = {~code_q[CTRL_W-1], code_q[CTRL_W-2:0]};
   assign bus.busy        = busy_q;
   assign bus.search_done = done_q;
   assign bus.lock        = lock_q;
   assign bus.ferr        = ferr_q;
endmodule
